// File: rtl/clk_mux_pkg.sv
// Shared constants for the glitch-free clock multiplexer.
// Holds the synchronizer depth default and its legal range.
`timescale 1ns/1ps
package clk_mux_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  function automatic bit sync_stages_ok(input int n);
    return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
  endfunction

endpackage

// File: rtl/clk_mux_if.sv
// Select/output bundle of the clock multiplexer.
// master drives sel and observes clk_o; slave is the mux side.
`timescale 1ns/1ps
interface clk_mux_if;

  logic sel;
  logic clk_o;

  modport master (
    output sel,
    input  clk_o
  );

  modport slave (
    input  sel,
    output clk_o
  );

endinterface

// File: rtl/clk_mux_sync.sv
// Negedge enable synchronizer with async active-low clear.
// Ports: clk_i, rst_ni, d_i (async), q_o (enable, changes on fall).
`timescale 1ns/1ps
module clk_mux_sync
  import clk_mux_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] q;

  // Falling edge so the enable only moves while clk_i is low.
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q <= '0;
    end else begin
      q <= {q[STAGES-2:0], d_i};
    end
  end

  assign q_o = q[STAGES-1];

endmodule

// File: rtl/clk_mux.sv
// Glitch-free two-input clock multiplexer (break-before-make).
// Ports: arst_ni, clk0_i, clk1_i, sel_i (async), clk_o.
`timescale 1ns/1ps
module clk_mux
  import clk_mux_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic arst_ni,
  input  logic clk0_i,
  input  logic clk1_i,
  input  logic sel_i,
  output logic clk_o
);

  logic en_0;
  logic en_1;
  logic d_0;
  logic d_1;

  // Each path may only request on once the other has
  // fully dropped, so the enables are never both high.
  assign d_0 = ~sel_i & ~en_1;
  assign d_1 =  sel_i & ~en_0;

  clk_mux_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync_0 (
    .clk_i  (clk0_i),
    .rst_ni (arst_ni),
    .d_i    (d_0),
    .q_o    (en_0)
  );

  clk_mux_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync_1 (
    .clk_i  (clk1_i),
    .rst_ni (arst_ni),
    .d_i    (d_1),
    .q_o    (en_1)
  );

  assign clk_o = (clk0_i & en_0) | (clk1_i & en_1);

endmodule

// File: tb/tb_clk_mux.sv
// Self-checking bench for clk_mux.
// Table of selections plus reset/toggle/stopped-clock sequences.
`timescale 1ns/1ps
module tb_clk_mux;

  typedef struct {
    logic sel;
    logic en0;
    logic en1;
  } vec_t;

  logic clk0;
  logic clk1;
  logic arst_n = 1'b0;
  logic clk0_run = 1'b1;

  int checks = 0;
  int errors = 0;

  clk_mux_if bus ();

  clk_mux #(
    .SYNC_STAGES (2)
  ) dut (
    .arst_ni (arst_n),
    .clk0_i  (clk0),
    .clk1_i  (clk1),
    .sel_i   (bus.sel),
    .clk_o   (bus.clk_o)
  );

  initial begin
    clk0 = 1'b0;
    #2;
    forever begin
      #5;
      clk0 = clk0_run ? ~clk0 : 1'b0;
    end
  end

  initial begin
    clk1 = 1'b0;
    #1;
    forever #8.5 clk1 = ~clk1;
  end

  task automatic chk(input string name, input logic act,
                     input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic logic clk_of(input logic src);
    return src ? clk1 : clk0;
  endfunction

  // Pulse-width monitor; pulses cut short by reset are exempt.
  realtime t_rise = 0.0;
  realtime t_fall = 0.0;
  bit seen_fall = 1'b0;

  always @(posedge bus.clk_o) begin
    if (seen_fall && arst_n) begin
      checks++;
      if ($realtime - t_fall < 4.999) begin
        errors++;
        $display("FAIL low_pulse: got %0.3f ns, expected >= 5 ns",
                 $realtime - t_fall);
      end
    end
    t_rise = $realtime;
  end

  always @(negedge bus.clk_o) begin
    if (arst_n && t_rise > 0.0) begin
      checks++;
      if ($realtime - t_rise < 4.999) begin
        errors++;
        $display("FAIL high_pulse: got %0.3f ns, expected >= 5 ns",
                 $realtime - t_rise);
      end
    end
    t_fall = $realtime;
    seen_fall = 1'b1;
  end

  wire both_en = dut.en_0 & dut.en_1;

  always @(posedge both_en) begin
    checks++;
    errors++;
    $display("FAIL mutex: got en_0=1 en_1=1, expected not both");
  end

  task automatic wait_level(input logic src, input logic lvl,
                            output bit ok);
    int n = 0;
    while (clk_of(src) !== lvl && n < 300) begin
      #0.1;
      n++;
    end
    ok = (clk_of(src) === lvl);
  endtask

  task automatic check_follow(input logic src, input string tag);
    bit ok;
    for (int i = 0; i < 3; i++) begin
      wait_level(src, 1'b1, ok);
      #1;
      chk({tag, "_hi"}, bus.clk_o, ok ? 1'b1 : 1'bx);
      wait_level(src, 1'b0, ok);
      #1;
      chk({tag, "_lo"}, bus.clk_o, ok ? 1'b0 : 1'bx);
    end
  endtask

  task automatic wait_en(input logic e0, input logic e1,
                         input realtime lim, output realtime lat);
    realtime t0 = $realtime;
    while ((dut.en_0 !== e0 || dut.en_1 !== e1) &&
           ($realtime - t0 < lim))
      #0.1;
    lat = $realtime - t0;
  endtask

  task automatic watch_low(input realtime dur, output bit hi);
    realtime t0 = $realtime;
    hi = 1'b0;
    while ($realtime - t0 < dur) begin
      if (bus.clk_o !== 1'b0) hi = 1'b1;
      #0.5;
    end
  endtask

  vec_t tbl[5];
  vec_t sb[$];
  vec_t e;
  realtime lat;
  bit hi;
  bit ok;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b0};

    // Reset with sel=0: clk_o held low, then clk0 within 2 falls.
    bus.sel = 1'b0;
    watch_low(20.0, hi);
    chk("rst_low", hi, 1'b0);
    arst_n = 1'b1;
    @(negedge clk0);
    @(negedge clk0);
    #1;
    chk("rel_en0", dut.en_0, 1'b1);
    chk("rel_en1", dut.en_1, 1'b0);
    check_follow(1'b0, "rel_follow");

    // Table of selections, scoreboarded by expected enables.
    for (int i = 0; i < 5; i++) begin
      bus.sel = tbl[i].sel;
      sb.push_back(tbl[i]);
      wait_en(tbl[i].en0, tbl[i].en1, 80.0, lat);
      e = sb.pop_front();
      chk($sformatf("v%0d_en0", i), dut.en_0, e.en0);
      chk($sformatf("v%0d_en1", i), dut.en_1, e.en1);
      chk($sformatf("v%0d_lat", i), lat <= 60.0, 1'b1);
      check_follow(e.sel, $sformatf("v%0d_follow", i));
    end

    // Short 0->1->0 blip: must settle back on clk0.
    bus.sel = 1'b1;
    #3;
    bus.sel = 1'b0;
    #60;
    wait_en(1'b1, 1'b0, 80.0, lat);
    chk("blip_en0", dut.en_0, 1'b1);
    chk("blip_en1", dut.en_1, 1'b0);
    check_follow(1'b0, "blip_follow");

    // Reset while clk_o is high during a 0->1 switch.
    wait_level(1'b0, 1'b1, ok);
    bus.sel = 1'b1;
    #1;
    chk("mid_hi", bus.clk_o, ok ? 1'b1 : 1'bx);
    arst_n = 1'b0;
    #0.1;
    chk("mid_rst_low", bus.clk_o, 1'b0);
    watch_low(20.0, hi);
    chk("mid_rst_hold", hi, 1'b0);
    wait_level(1'b1, 1'b1, ok);
    #1;
    arst_n = 1'b1;
    @(negedge clk1);
    @(negedge clk1);
    #1;
    chk("mid_rel_en1", dut.en_1, 1'b1);
    chk("mid_rel_en0", dut.en_0, 1'b0);
    check_follow(1'b1, "mid_follow");

    // Old clock stopped: switch stalls until clk0 returns.
    bus.sel = 1'b0;
    wait_en(1'b1, 1'b0, 80.0, lat);
    chk("stop_pre_en0", dut.en_0, 1'b1);
    clk0_run = 1'b0;
    #20;
    bus.sel = 1'b1;
    watch_low(200.0, hi);
    chk("stop_low", hi, 1'b0);
    chk("stop_en1", dut.en_1, 1'b0);
    chk("stop_en0", dut.en_0, 1'b1);
    clk0_run = 1'b1;
    wait_en(1'b0, 1'b1, 100.0, lat);
    chk("resume_en1", dut.en_1, 1'b1);
    chk("resume_en0", dut.en_0, 1'b0);
    check_follow(1'b1, "resume_follow");

    chk("final_mutex", both_en, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
